// File: rtl/spfifo_ctl_pkg.sv
// Shared defaults for the single-port FIFO controller and the RAM wrapper it drives.
package spfifo_ctl_pkg;

  localparam int ADDRBIT_DEF = 11;
  localparam int DEPTH_DEF   = 1536;
  localparam int WIDTH_DEF   = 32;
  // Read latency of the wrapped single-port RAM macro, in clocks.
  localparam int RDLAT_DEF   = 3;

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

endpackage

// File: rtl/spfifo_obuf.sv
// Small output queue that catches RAM read data; sized so every in-flight read has a slot.
module spfifo_obuf
  import spfifo_ctl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ENTRIES = RDLAT_DEF + 1
) (
  input  logic                             clk,
  input  logic                             rst_,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_dat,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(ENTRIES+1)-1:0]     free_cnt
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES + 1);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (cnt != '0);
  assign do_push  = push && ((cnt != CW'(ENTRIES)) || do_pop);
  assign full     = (cnt == CW'(ENTRIES));
  assign empty    = (cnt == '0);
  assign free_cnt = CW'(ENTRIES) - cnt;
  assign head     = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_idx <= (wr_idx == IW'(ENTRIES - 1)) ? '0 : wr_idx + IW'(1);
      if (do_pop)  rd_idx <= (rd_idx == IW'(ENTRIES - 1)) ? '0 : rd_idx + IW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spfifo_ctl.sv
// FIFO controller around a single-port RAM: one holding register in, a credit-managed
// output buffer out, and a scheduler issuing at most one RAM write or read per clock.
module spfifo_ctl
  import spfifo_ctl_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RDLAT   = RDLAT_DEF
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               wr_vld,
  input  logic [WIDTH-1:0]   wr_dat,
  output logic               wr_rdy,
  output logic               rd_vld,
  output logic [WIDTH-1:0]   rd_dat,
  input  logic               rd_rdy,
  output logic [ADDRBIT-1:0] mem_a,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_di,
  input  logic [WIDTH-1:0]   mem_do,
  output logic [ADDRBIT:0]   fill
);

  localparam int                 CW       = $clog2(RDLAT + 2);
  localparam logic [ADDRBIT:0]   RAM_MAX  = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] PTR_LAST = ADDRBIT'(DEPTH - 1);

  logic               hold_vld;
  logic [WIDTH-1:0]   hold_dat;
  logic [ADDRBIT-1:0] wptr;
  logic [ADDRBIT-1:0] rptr;
  logic [ADDRBIT:0]   ram_cnt;
  logic [RDLAT-1:0]   pipe;
  logic               last_read;
  logic               init_done;
  logic [ADDRBIT:0]   fill_q;
  logic [CW-1:0]      obuf_free;
  logic [CW-1:0]      inflight;
  logic               obuf_full;
  logic               obuf_empty;
  logic               rd_ok;
  logic               wr_ok;
  logic [1:0]         op;
  logic               acc;
  logic               con;

  // Credit: a read may only be issued if the output buffer can still hold it once
  // every read already travelling through the RAM pipe has landed.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) inflight = inflight + CW'(pipe[i]);
  end

  assign rd_ok = (ram_cnt != '0) && !obuf_full && (obuf_free > inflight);
  assign wr_ok = hold_vld && (ram_cnt < RAM_MAX);

  // When both sides want the port they take turns, which keeps streaming at one word per two clocks.
  always_comb begin
    op = OP_IDLE;
    if (wr_ok && rd_ok) op = last_read ? OP_WRITE : OP_READ;
    else if (wr_ok)     op = OP_WRITE;
    else if (rd_ok)     op = OP_READ;
  end

  assign mem_we = (op == OP_WRITE);
  assign mem_a  = (op == OP_WRITE) ? wptr : ((op == OP_READ) ? rptr : '0);
  assign mem_di = (op == OP_WRITE) ? hold_dat : '0;
  assign wr_rdy = init_done && (!hold_vld || mem_we);
  assign rd_vld = !obuf_empty;
  assign acc    = wr_vld && wr_rdy;
  assign con    = rd_vld && rd_rdy;
  assign fill   = fill_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      pipe      <= '0;
      last_read <= 1'b1;
      init_done <= 1'b0;
      fill_q    <= '0;
    end else begin
      init_done <= 1'b1;
      if (acc) begin
        hold_vld <= 1'b1;
        hold_dat <= wr_dat;
      end else if (mem_we) begin
        hold_vld <= 1'b0;
      end
      if (op == OP_WRITE) begin
        wptr    <= (wptr == PTR_LAST) ? '0 : wptr + ADDRBIT'(1);
        ram_cnt <= ram_cnt + (ADDRBIT+1)'(1);
      end else if (op == OP_READ) begin
        rptr    <= (rptr == PTR_LAST) ? '0 : rptr + ADDRBIT'(1);
        ram_cnt <= ram_cnt - (ADDRBIT+1)'(1);
      end
      if (op != OP_IDLE) last_read <= (op == OP_READ);
      pipe <= (pipe << 1) | RDLAT'(op == OP_READ);
      case ({acc, con})
        2'b10:   fill_q <= fill_q + (ADDRBIT+1)'(1);
        2'b01:   fill_q <= fill_q - (ADDRBIT+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  spfifo_obuf #(
    .WIDTH   (WIDTH),
    .ENTRIES (RDLAT + 1)
  ) u_obuf (
    .clk      (clk),
    .rst_     (rst_),
    .push     (pipe[RDLAT-1]),
    .push_dat (mem_do),
    .pop      (con),
    .head     (rd_dat),
    .full     (obuf_full),
    .empty    (obuf_empty),
    .free_cnt (obuf_free)
  );

endmodule
